// File: rtl/wb_regfile_if.sv
// Bus bundle for wb_regfile: writeback input, issue/scoreboard handshake and the two decode read ports.
interface wb_regfile_if #(
  parameter int DATA_W = 16
);
  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              iss_valid;
  logic [3:0]        iss_rd;
  logic [3:0]        iss_rs1;
  logic [3:0]        iss_rs2;
  logic              iss_use1;
  logic              iss_use2;
  logic              iss_stall;

  logic [3:0]        rd1_addr;
  logic [3:0]        rd2_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  logic [15:0]       busy;
  logic              commit_valid;
  logic [3:0]        commit_rd;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output iss_valid, iss_rd, iss_rs1, iss_rs2, iss_use1, iss_use2,
    output rd1_addr, rd2_addr,
    input  iss_stall, rd1_data, rd2_data, busy, commit_valid, commit_rd
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2, iss_use1, iss_use2,
    input  rd1_addr, rd2_addr,
    output iss_stall, rd1_data, rd2_data, busy, commit_valid, commit_rd
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage + 16x16 register file: results are staged one cycle then committed, bypassed to reads.
// Busy-bit scoreboard stalls issue on RAW/WAW hazards using registered busy only (no wb lookahead).
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);
  logic [DATA_W-1:0] regs [NREG];

  logic              pend_v;
  logic [3:0]        pend_rd;
  logic [DATA_W-1:0] pend_data;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;
  logic              stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_rd   <= '0;
      pend_data <= '0;
    end else begin
      pend_v <= bus.wb_valid;
      if (bus.wb_valid) begin
        pend_rd   <= bus.wb_rd;
        pend_data <= bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (pend_v) begin
      regs[pend_rd] <= pend_data;
    end
  end

  always_comb begin
    stall    = 1'b0;
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid) begin
      stall = (bus.iss_use1 && busy_q[bus.iss_rs1]) ||
              (bus.iss_use2 && busy_q[bus.iss_rs2]) ||
              busy_q[bus.iss_rd];
    end
    if (bus.iss_valid && !stall) begin
      set_mask = NREG'(1) << bus.iss_rd;
    end
    if (bus.wb_valid) begin
      clr_mask = NREG'(1) << bus.wb_rd;
    end
  end

  // Set is OR'ed in after the clear, so a same-edge issue keeps the bit busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  assign bus.iss_stall    = stall;
  assign bus.busy         = busy_q;
  assign bus.commit_valid = pend_v;
  assign bus.commit_rd    = pend_rd;

  // Only the staged result is bypassed; wb_data itself never reaches the read ports.
  assign bus.rd1_data = (pend_v && pend_rd == bus.rd1_addr) ? pend_data : regs[bus.rd1_addr];
  assign bus.rd2_data = (pend_v && pend_rd == bus.rd2_addr) ? pend_data : regs[bus.rd2_addr];
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 16-register, 16-bit CPU. It sits directly downstream of the writeback demux stage: it takes the ALU result plus its 4-bit destination index, stages it for one cycle, then commits it into a 16×16 register array. It also provides two bypassed read ports for decode and a busy-bit scoreboard that stalls issue on register hazards.

## Interface
- DATA_W, 16, register width
- NREG, 16, number of registers; the address width is fixed at 4 bits
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  result present this cycle
- wb_rd  in  4  destination register index (same encoding as opcode_rd)
- wb_data  in  16  result value
- iss_valid  in  1  decode wants to issue an instruction
- iss_rd  in  4  destination register of the issuing instruction
- iss_rs1, iss_rs2  in  4 each  source register indices
- iss_use1, iss_use2  in  1 each  source is actually read
- iss_stall  out  1  issue blocked this cycle (combinational)
- rd1_addr, rd2_addr  in  4 each  read addresses
- rd1_data, rd2_data  out  16 each  read data (combinational)
- busy  out  16  scoreboard bits, registered
- commit_valid  out  1  an array write happens at the next edge
- commit_rd  out  4  index of that write

## Operation
- Pending stage (pend_v, pend_rd, pend_data):
  - On each edge, pend_v <= wb_valid; pend_rd and pend_data load only when wb_valid = 1.
- Commit:
  - On each edge, if pend_v = 1 then regs[pend_rd] <= pend_data.
  - commit_valid = pend_v; commit_rd = pend_rd.
- Read ports:
  - rdX_data = pend_data if pend_v && pend_rd == rdX_addr; otherwise regs[rdX_addr].
  - wb_data is never bypassed directly to the read ports.
- Scoreboard:
  - set_mask = one-hot(iss_rd) when iss_valid && !iss_stall.
  - clr_mask = one-hot(wb_rd) when wb_valid.
  - busy <= (busy & ~clr_mask) | set_mask. Set wins when the same index is both set and cleared.
  - A clear of a non-busy bit is a no-op; the data write still happens.
- Stall:
  - iss_stall = iss_valid && ((iss_use1 && busy[iss_rs1]) || (iss_use2 && busy[iss_rs2]) || busy[iss_rd]).
  - The busy[iss_rd] term enforces WAW ordering.
  - Stall uses registered busy only, with no same-cycle lookahead on wb_valid.
- All 16 registers are writable; there is no hardwired zero.

## Timing
- Reset (asynchronous, any time):
  - regs all 0, pend_v = 0, busy = 0.
  - commit_valid = 0, commit_rd = 0, iss_stall = 0 (combinational from busy = 0).
  - A pending write in flight is dropped.
- Write latency:
  - wb_valid sampled at edge N is visible on the read ports after edge N via the bypass.
  - It is in the array after edge N+1.
  - busy clears at edge N, so an instruction stalled on it issues in cycle N+1.
- Back-to-back writes to the same rd at edges N and N+1:
  - Array holds the first value after N+1 and the second after N+2.
  - Reads after N+1 return the second value.
- Back-to-back writes to different rd: one commit per cycle, no loss.
- Issue with a zero-cycle result (set and clear in the same edge): busy stays 1.

## Test plan
- Reset: drive wb_valid = 1, rd = 5, data = 0x1234, then assert rst_n = 0 mid-cycle -> regs[5] = 0, busy = 0, commit_valid = 0 immediately.
- Basic write: wb r3 = 0xBEEF at edge 1 -> rd1_addr = 3 reads 0xBEEF after edge 1 (bypass) and after edge 2 (array); commit_valid = 1 in cycle 1 only.
- Same-rd burst: wb r7 = 0x0001, then 0x0002 on consecutive edges -> reads show 0x0002 after edge 2; regs[7] = 0x0002 after edge 3.
- RAW stall: issue rd = 4; next cycle issue rs1 = 4, use1 = 1 -> iss_stall = 1 until the cycle after wb r4 is sampled, then iss_stall = 0.
- WAW plus set/clear collision: busy[9] = 1; in one cycle wb_rd = 9 and a non-stalled issue with iss_rd = 9 -> busy[9] remains 1. (The issue stalls on busy[9] unless busy was clear, so force this with busy[9] = 0 and a spurious wb_rd = 9 -> busy[9] = 1.)
- Dual-port independence: rd1_addr = 0, rd2_addr = 15 after writes 0xAAAA and 0x5555 -> both values returned in the same cycle.
